// File: rtl/iob_cache_axi_read_responder_if.sv
// rtl/iob_cache_axi_read_responder_if.sv - AXI4 AR/R channel bundle for the read responder
interface iob_cache_axi_read_responder_if #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8
);
    logic [AXI_ID_W-1:0]   axi_arid_i;
    logic [AXI_ADDR_W-1:0] axi_araddr_i;
    logic [AXI_LEN_W-1:0]  axi_arlen_i;
    logic [2:0]            axi_arsize_i;
    logic [1:0]            axi_arburst_i;
    logic                  axi_arvalid_i;
    logic                  axi_arready_o;
    logic [AXI_ID_W-1:0]   axi_rid_o;
    logic [AXI_DATA_W-1:0] axi_rdata_o;
    logic [1:0]            axi_rresp_o;
    logic                  axi_rlast_o;
    logic                  axi_rvalid_o;
    logic                  axi_rready_i;

    modport slave (
        input  axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
        input  axi_arvalid_i, axi_rready_i,
        output axi_arready_o, axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o
    );

    modport master (
        output axi_arid_i, axi_araddr_i, axi_arlen_i, axi_arsize_i, axi_arburst_i,
        output axi_arvalid_i, axi_rready_i,
        input  axi_arready_o, axi_rid_o, axi_rdata_o, axi_rresp_o, axi_rlast_o, axi_rvalid_o
    );
endinterface

// File: rtl/iob_cache_axi_read_responder.sv
// rtl/iob_cache_axi_read_responder.sv - AXI4 read slave over a 1-cycle-latency memory, 2-entry R buffer
// Optional out-of-range SLVERR beats: define IOB_CACHE_AXI_RD_SLVERR_EN.
module iob_cache_axi_read_responder #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_ADDR_W = 16
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    iob_cache_axi_read_responder_if.slave         axi,
    output logic                                  mem_en_o,
    output logic [MEM_ADDR_W-1:0]                 mem_addr_o,
    input  logic [AXI_DATA_W-1:0]                 mem_rdata_i
);
    localparam int OFFS_W = $clog2(AXI_DATA_W / 8);
`ifdef IOB_CACHE_AXI_RD_SLVERR_EN
    // Keep the untruncated word address so out-of-range beats can be flagged.
    localparam int AR_W = AXI_ADDR_W - OFFS_W;
`else
    localparam int AR_W = MEM_ADDR_W;
`endif
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [AR_W-1:0]       addr_q, addr_d;
    logic [AXI_LEN_W-1:0]  cnt_q, cnt_d;
    logic                  fixed_q, fixed_d;

    logic                  if_valid_q, if_valid_d;
    logic [AXI_ID_W-1:0]   if_id_q, if_id_d;
    logic [1:0]            if_resp_q, if_resp_d;
    logic                  if_last_q, if_last_d;

    logic [AXI_DATA_W-1:0] fifo_data_q [2];
    logic [AXI_DATA_W-1:0] fifo_data_d [2];
    logic [AXI_ID_W-1:0]   fifo_id_q   [2];
    logic [AXI_ID_W-1:0]   fifo_id_d   [2];
    logic [1:0]            fifo_resp_q [2];
    logic [1:0]            fifo_resp_d [2];
    logic [1:0]            fifo_last_q, fifo_last_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  arready;
    logic                  rvalid;
    logic                  pop;
    logic                  push;
    logic [2:0]            occupancy;
    logic                  credit;
    logic                  issue;
    logic                  in_range;
    logic                  unused_ok;

    assign unused_ok = &{1'b0, axi.axi_arsize_i, axi.axi_araddr_i};

`ifdef IOB_CACHE_AXI_RD_SLVERR_EN
    localparam logic [AR_W:0] MEM_WORDS = {{AR_W{1'b0}}, 1'b1} << MEM_ADDR_W;
    assign in_range = ({1'b0, addr_q} < MEM_WORDS);
`else
    assign in_range = 1'b1;
`endif

    assign rvalid = (count_q != 2'd0);
    assign pop    = rvalid & axi.axi_rready_i;
    assign push   = if_valid_q;

    // Slots already promised (buffered + in flight) after this cycle's pop must leave room.
    assign occupancy = 3'(count_q) + 3'(if_valid_q) - 3'(pop);
    assign credit    = (occupancy < 3'd2);
    assign issue     = (state_q == ST_ISSUE) && credit;

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        fixed_d    = fixed_q;
        arready    = 1'b0;
        if_valid_d = issue;
        if_id_d    = id_q;
        if_resp_d  = in_range ? RESP_OKAY : RESP_SLVERR;
        if_last_d  = (cnt_q == '0);

        case (state_q)
            ST_IDLE: begin
                arready = 1'b1;
                if (axi.axi_arvalid_i) begin
                    id_d    = axi.axi_arid_i;
                    addr_d  = axi.axi_araddr_i[OFFS_W +: AR_W];
                    cnt_d   = axi.axi_arlen_i;
                    fixed_d = (axi.axi_arburst_i == 2'b00);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + (fixed_q ? '0 : AR_W'(1));
                    cnt_d  = cnt_q - AXI_LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_id_d   = fifo_id_q;
        fifo_resp_d = fifo_resp_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q ^ push;
        rd_ptr_d    = rd_ptr_q ^ pop;
        count_d     = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            // Error beats never strobed the memory, so mem_rdata_i is meaningless for them.
            fifo_data_d[wr_ptr_q] = (if_resp_q == RESP_SLVERR) ? '0 : mem_rdata_i;
            fifo_id_d[wr_ptr_q]   = if_id_q;
            fifo_resp_d[wr_ptr_q] = if_resp_q;
            fifo_last_d[wr_ptr_q] = if_last_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            fixed_q     <= 1'b0;
            if_valid_q  <= 1'b0;
            if_id_q     <= '0;
            if_resp_q   <= RESP_OKAY;
            if_last_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
                fifo_id_q[i]   <= '0;
                fifo_resp_q[i] <= RESP_OKAY;
            end
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            fixed_q     <= fixed_d;
            if_valid_q  <= if_valid_d;
            if_id_q     <= if_id_d;
            if_resp_q   <= if_resp_d;
            if_last_q   <= if_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_id_q   <= fifo_id_d;
            fifo_resp_q <= fifo_resp_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign mem_en_o   = issue && in_range;
    assign mem_addr_o = addr_q[MEM_ADDR_W-1:0];

    assign axi.axi_arready_o = arready;
    assign axi.axi_rvalid_o  = rvalid;
    assign axi.axi_rdata_o   = fifo_data_q[rd_ptr_q];
    assign axi.axi_rid_o     = fifo_id_q[rd_ptr_q];
    assign axi.axi_rresp_o   = fifo_resp_q[rd_ptr_q];
    assign axi.axi_rlast_o   = fifo_last_q[rd_ptr_q];
endmodule

// File: tb/tb_iob_cache_axi_read_responder.sv
// tb/tb_iob_cache_axi_read_responder.sv - randomized bench with a burst-level reference model
module tb_iob_cache_axi_read_responder;
    localparam int MEM_ADDR_W = 4;
`ifdef IOB_CACHE_AXI_RD_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [0:0]  id;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic reset_n;
    logic mem_en;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem [16];

    beat_t exp_q [$];
    logic [3:0] addr_exp_q [$];
    beat_t obs [$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_issue = 0;
    int rmode = 1;

    iob_cache_axi_read_responder_if #(.AXI_ID_W(1), .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_LEN_W(8)) axi_if ();

    iob_cache_axi_read_responder #(
        .AXI_ID_W(1), .AXI_ADDR_W(32), .AXI_DATA_W(32), .AXI_LEN_W(8), .MEM_ADDR_W(MEM_ADDR_W)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .axi(axi_if),
        .mem_en_o(mem_en), .mem_addr_o(mem_addr), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: axi_if.axi_rready_i = 1'b0;
            1: axi_if.axi_rready_i = 1'b1;
            default: axi_if.axi_rready_i = ($urandom_range(0, 3) != 0);
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-burst expansion: every beat's word, data, response and last flag.
    task automatic model_ar(input logic [0:0] id, input logic [31:0] araddr, input int len, input logic [1:0] burst);
        logic [29:0] w;
        logic err;
        beat_t b;
        for (int i = 0; i <= len; i++) begin
            w   = (burst == 2'b00) ? araddr[31:2] : araddr[31:2] + 30'(i);
            err = SLV && (w >= 30'd16);
            b.data = err ? 32'h0 : mem[w[3:0]];
            b.id   = id;
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == len);
            exp_q.push_back(b);
            if (!err) addr_exp_q.push_back(w[3:0]);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_en) begin
                n_issue++;
                if (addr_exp_q.size() == 0) chk("mem_en_unexpected", 1, 0);
                else chk("mem_addr", 64'(mem_addr), 64'(addr_exp_q.pop_front()));
            end
            if (axi_if.axi_rvalid_o) begin
                if (exp_q.size() == 0) chk("rvalid_unexpected", 1, 0);
                else begin
                    chk("rdata", 64'(axi_if.axi_rdata_o), 64'(exp_q[0].data));
                    chk("rid",   64'(axi_if.axi_rid_o),   64'(exp_q[0].id));
                    chk("rresp", 64'(axi_if.axi_rresp_o), 64'(exp_q[0].resp));
                    chk("rlast", 64'(axi_if.axi_rlast_o), 64'(exp_q[0].last));
                    if (axi_if.axi_rready_i) begin
                        obs.push_back(exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (axi_if.axi_arvalid_i && axi_if.axi_arready_o)
                model_ar(axi_if.axi_arid_i, axi_if.axi_araddr_i, int'(axi_if.axi_arlen_i), axi_if.axi_arburst_i);
        end
    end

    task automatic send_ar(input logic [0:0] id, input logic [31:0] addr, input int len, input logic [1:0] burst);
        int tries = 0;
        @(posedge clk); #1;
        axi_if.axi_arid_i    = id;
        axi_if.axi_araddr_i  = addr;
        axi_if.axi_arlen_i   = 8'(len);
        axi_if.axi_arsize_i  = 3'd2;
        axi_if.axi_arburst_i = burst;
        axi_if.axi_arvalid_i = 1'b1;
        do begin
            @(negedge clk);
            tries++;
        end while (!axi_if.axi_arready_o && tries < 200);
        if (tries >= 200) chk("arready_timeout", 0, 1);
        @(posedge clk); #1;
        axi_if.axi_arvalid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        if (rmode == 0) rmode = 1;
        while ((exp_q.size() != 0 || !axi_if.axi_arready_o) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) chk("drain_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_rvalid"},  64'(axi_if.axi_rvalid_o), 0);
        chk({tag, "_rlast"},   64'(axi_if.axi_rlast_o), 0);
        chk({tag, "_rresp"},   64'(axi_if.axi_rresp_o), 0);
        chk({tag, "_rid"},     64'(axi_if.axi_rid_o), 0);
        chk({tag, "_rdata"},   64'(axi_if.axi_rdata_o), 0);
        chk({tag, "_mem_en"},  64'(mem_en), 0);
        chk({tag, "_mem_addr"},64'(mem_addr), 0);
        chk({tag, "_arready"}, 64'(axi_if.axi_arready_o), 1);
    endtask

    initial begin
        int n, cnt, t;
        reset_n = 1'b0;
        axi_if.axi_arvalid_i = 1'b0;
        axi_if.axi_arid_i = '0;
        axi_if.axi_araddr_i = '0;
        axi_if.axi_arlen_i = '0;
        axi_if.axi_arsize_i = '0;
        axi_if.axi_arburst_i = '0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[4] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset_n = 1'b1;

        // single beat: latency and literal values
        rmode = 1;
        send_ar(1'b1, 32'h10, 0, 2'b01);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("mem_en_first_cycle", 64'(mem_en), 1);
        end while (!axi_if.axi_rvalid_o && n < 10);
        chk("first_beat_latency", 64'(n), 3);
        chk("single_rdata", 64'(axi_if.axi_rdata_o), 64'h DEADBEEF);
        chk("single_rlast", 64'(axi_if.axi_rlast_o), 1);
        chk("single_rresp", 64'(axi_if.axi_rresp_o), 0);
        chk("single_rid",   64'(axi_if.axi_rid_o), 1);
        drain();

        // INCR 4 beats, arready returns the cycle after the 4th issue
        obs.delete();
        send_ar(1'b0, 32'h0, 3, 2'b01);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 4) chk("arready_during_last_issue", 64'(axi_if.axi_arready_o), 0);
            if (k == 5) chk("arready_after_last_issue", 64'(axi_if.axi_arready_o), 1);
        end
        drain();
        chk("incr_beats", 64'(obs.size()), 4);
        for (int k = 0; k < 4 && k < obs.size(); k++) begin
            chk("incr_data", 64'(obs[k].data), 64'(mem[k]));
            chk("incr_last", 64'(obs[k].last), (k == 3) ? 1 : 0);
        end

        // backpressure: only two beats buffered while rready is low
        obs.delete();
        rmode = 0;
        cnt = n_issue;
        send_ar(1'b1, 32'h0, 3, 2'b01);
        t = 0;
        do begin @(negedge clk); t++; end while (!axi_if.axi_rvalid_o && t < 10);
        repeat (5) @(negedge clk);
        chk("bp_issued_while_stalled", 64'(n_issue - cnt), 2);
        chk("bp_mem_en_low", 64'(mem_en), 0);
        rmode = 1;
        drain();
        chk("bp_beats", 64'(obs.size()), 4);
        for (int k = 0; k < 4 && k < obs.size(); k++)
            chk("bp_order", 64'(obs[k].data), 64'(mem[k]));

        // FIXED burst stays on word 8
        obs.delete();
        cnt = 0;
        send_ar(1'b0, 32'h20, 2, 2'b00);
        repeat (6) begin
            @(negedge clk);
            if (mem_en) begin
                cnt++;
                chk("fixed_addr", 64'(mem_addr), 8);
            end
        end
        chk("fixed_issues", 64'(cnt), 3);
        drain();
        chk("fixed_beats", 64'(obs.size()), 3);
        if (obs.size() == 3) begin
            chk("fixed_last1", 64'(obs[1].last), 0);
            chk("fixed_last2", 64'(obs[2].last), 1);
            chk("fixed_data", 64'(obs[2].data), 64'(mem[8]));
        end

        // crossing the top of the 16-word memory
        obs.delete();
        send_ar(1'b1, 32'h38, 3, 2'b01);
        drain();
        chk("edge_beats", 64'(obs.size()), 4);
        if (obs.size() == 4) begin
            chk("edge_b0", 64'(obs[0].data), 64'(mem[14]));
            chk("edge_b1", 64'(obs[1].data), 64'(mem[15]));
            chk("edge_b0_resp", 64'(obs[0].resp), 0);
            chk("edge_b2_resp", 64'(obs[2].resp), SLV ? 2 : 0);
            chk("edge_b3_resp", 64'(obs[3].resp), SLV ? 2 : 0);
            chk("edge_b2_data", 64'(obs[2].data), SLV ? 0 : 64'(mem[0]));
            chk("edge_b3_data", 64'(obs[3].data), SLV ? 0 : 64'(mem[1]));
            chk("edge_b3_last", 64'(obs[3].last), 1);
        end

        // reset in the middle of an 8-beat burst
        obs.delete();
        send_ar(1'b0, 32'h0, 7, 2'b01);
        t = 0;
        while (obs.size() < 2 && t < 50) begin @(negedge clk); t++; end
        chk("midburst_reached", 64'(obs.size()), 2);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        exp_q.delete();
        addr_exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        obs.delete();
        send_ar(1'b1, 32'h14, 1, 2'b01);
        drain();
        chk("post_reset_beats", 64'(obs.size()), 2);
        if (obs.size() == 2) begin
            chk("post_reset_b0", 64'(obs[0].data), 64'(mem[5]));
            chk("post_reset_b1", 64'(obs[1].data), 64'(mem[6]));
            chk("post_reset_last", 64'(obs[1].last), 1);
        end

        // randomized bursts with random backpressure and overlapping requests
        for (int k = 0; k < 80; k++) begin
            logic [31:0] a;
            rmode = $urandom_range(1, 2);
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
            send_ar(1'($urandom), a, $urandom_range(0, 7), 2'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
        end
        drain();
        chk("final_exp_empty", 64'(exp_q.size()), 0);
        chk("final_addr_empty", 64'(addr_exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/iob_cache_axi_read_responder.md
# iob_cache_axi_read_responder

AXI4 read-channel slave that answers AR/R bursts from a synchronous single-port backing memory with 1-cycle read latency. It is the far end of the cache's AXI read-channel master and serves as the back-end memory model and on-chip ROM/RAM front-end for cache line fills. It accepts one address request at a time and streams beats through a 2-entry output buffer, so `rready_i` backpressure never drops or duplicates data.

## Interface
- AXI_ID_W, 1, ID width.
- AXI_ADDR_W, 32, byte address width.
- AXI_DATA_W, 32, data width; power of two, at least 8.
- AXI_LEN_W, 8, burst length field width.
- MEM_ADDR_W, 16, backing-memory word address width.
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  reset, asynchronous, active-low (fixed).
- axi_arid_i  in  AXI_ID_W  request ID.
- axi_araddr_i  in  AXI_ADDR_W  byte start address.
- axi_arlen_i  in  AXI_LEN_W  beats minus 1.
- axi_arsize_i  in  3  ignored; every beat is full width.
- axi_arburst_i  in  2  00 FIXED; any other value is treated as INCR.
- axi_arvalid_i  in  1  request valid.
- axi_arready_o  out  1  request accepted.
- axi_rid_o  out  AXI_ID_W  echoed ID.
- axi_rdata_o  out  AXI_DATA_W  beat data.
- axi_rresp_o  out  2  00 OKAY, 10 SLVERR.
- axi_rlast_o  out  1  final beat.
- axi_rvalid_o  out  1  beat valid.
- axi_rready_i  in  1  beat accepted.
- mem_en_o  out  1  memory read strobe.
- mem_addr_o  out  MEM_ADDR_W  word address.
- mem_rdata_i  in  AXI_DATA_W  data for the strobe issued on the previous cycle.

## Operation
- Word address = araddr >> log2(AXI_DATA_W/8). Low byte bits are ignored.
- States:
  - IDLE: arready_o = 1. On arvalid & arready, latch ID, word address, beat count = arlen and FIXED flag, then go to ISSUE.
  - ISSUE: arready_o = 0. Each cycle in which credit allows, assert mem_en_o with the current address, then advance the address (+1 for INCR, unchanged for FIXED) and decrement the beat count. On the cycle the last beat issues, return to IDLE.
- Credit rule: issue only when fifo_count + inflight − (rvalid & rready) < 2. fifo_count is 0..2 and inflight is 0..1.
- In-flight stage: one register carries {id, resp, last} alongside the memory access. On the next cycle, mem_rdata_i (or 0 for an error beat) is pushed into the FIFO with those tags.
- Every FIFO entry holds {data, id, resp, last}. rvalid_o = FIFO non-empty; the R outputs show the FIFO head. Head data is held stable while rvalid_o is high and rready_i is low.
- A new burst may be accepted while the previous burst's beats are still in the FIFO. The per-entry ID keeps rid_o correct across that overlap.
- INCR addresses wrap modulo 2^MEM_ADDR_W unless IOB_CACHE_AXI_RD_SLVERR_EN is defined.

## Timing
- Reset (reset_n_i low, asynchronous):
  - State IDLE, FIFO empty, in-flight cleared.
  - rvalid_o, rlast_o, rresp_o, rid_o, rdata_o, mem_en_o and mem_addr_o are all 0. arready_o = 1.
- Latency: with the AR handshake at edge T, mem_en_o is high in cycle T+1, data is pushed at the end of T+2, and rvalid_o is high in T+3. First beat therefore appears 3 cycles after the handshake.
- Throughput: 1 beat/cycle with rready_i held high. Burst of N beats: last beat in cycle T+N+2.
- With rready_i low, at most 2 beats are buffered and mem_en_o stays low once credit is exhausted. Issue resumes the cycle rready_i returns.
- A simultaneous push and pop on a full FIFO is legal; the count stays 2.
- A reset mid-burst discards all beats. The next AR after reset is served from a clean state.
- arlen = 0: single beat, rlast = 1.

## Configuration
- IOB_CACHE_AXI_RD_SLVERR_EN:
  - Defined: each beat's full word address (AXI_ADDR_W − log2 bytes, not truncated) is range-checked. A beat with word address ≥ 2^MEM_ADDR_W issues no mem_en_o, returns rresp 10 and rdata 0, and still occupies its slot and credit so beat order and rlast are preserved.
  - Undefined: addresses are truncated to MEM_ADDR_W, rresp_o is always 00, and the out-of-range check is absent.

## Test plan
- Single beat, AXI_DATA_W=32: araddr 0x10, arlen 0, arid 1, memory word 4 = 0xDEADBEEF -> one beat 3 cycles after the handshake with rdata 0xDEADBEEF, rlast 1, rresp 00, rid 1.
- INCR, araddr 0, arlen 3, rready_i high -> 4 consecutive beats of words 0..3, rlast only on the 4th, arready_o high again the cycle after the 4th issue.
- Backpressure: same burst with rready_i low for 5 cycles after the first rvalid -> mem_en_o stops after 2 buffered, head stable, and all 4 beats delivered in order with none duplicated.
- FIXED, araddr 0x20, arlen 2 -> mem_addr_o is 8 on all 3 issues, 3 beats returned, rlast on the 3rd.
- MEM_ADDR_W=4, araddr 0x38, arlen 3:
  - Macro on: words 14 and 15 return OKAY, the next 2 beats return SLVERR with rdata 0 and rlast on beat 4.
  - Macro off: words 14, 15, 0, 1 all return OKAY.
- Reset asserted mid-burst at beat 2 of 8 -> all outputs 0 immediately. After release, a new burst of arlen 1 returns exactly 2 correct beats.
